// File: rtl/cmd_issuer_if.sv
// rtl/cmd_issuer_if.sv - command/response link between cmd_issuer and CommMaster
interface cmd_issuer_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        snd_cmd;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output cmd, data, snd_cmd,
        input  frm_snt, resp_rdy, resp
    );

    modport slave (
        input  cmd, data, snd_cmd,
        output frm_snt, resp_rdy, resp
    );
endinterface

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - issues one command per go, waits for frame/response, reports status (optional retries: CMD_ISSUE_RETRY_EN)
module cmd_issuer #(
    parameter int TMO_W     = 20,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [7:0]          cmd_in,
    input  logic [15:0]         data_in,
    cmd_issuer_if.master        link,
    output logic                busy,
    output logic                done,
    output logic                ack_ok,
    output logic                nak,
    output logic                tmo_err,
    output logic [7:0]          batt_lvl
);

    localparam logic [7:0] REQ_BATT = 8'h01;
    localparam logic [7:0] MAX_CODE = 8'h08;
    localparam logic [7:0] ACK      = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_FRM,
        WAIT_RESP,
        FIN
    } state_t;

    state_t             state;
    logic [7:0]         cmd_q;
    logic [15:0]        data_q;
    logic               snd_q;
    logic [TMO_W-1:0]   timer;

    logic               code_valid;
    logic               resp_good;
    logic               frm_now;
    logic               evt_ok;
    logic               evt_fail;
    logic               can_retry;

`ifdef CMD_ISSUE_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0]      retry;
    assign can_retry = int'(retry) < MAX_RETRY;
`else
    assign can_retry = 1'b0;
`endif

    assign link.cmd     = cmd_q;
    assign link.data    = data_q;
    assign link.snd_cmd = snd_q;

    // Event decode for the waiting states: a response byte always takes
    // priority over frame-sent and over the timeout.
    assign code_valid = (cmd_in != 8'h00) && (cmd_in <= MAX_CODE);
    assign resp_good  = (cmd_q == REQ_BATT) || (link.resp == ACK);
    assign frm_now    = (state == WAIT_FRM) && link.frm_snt;
    assign evt_ok     = link.resp_rdy && resp_good;
    assign evt_fail   = link.resp_rdy ? !resp_good : ((timer == '1) && !frm_now);

    // Transaction FSM with registered strobes and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= 8'h00;
            data_q   <= 16'h0000;
            snd_q    <= 1'b0;
            timer    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_ok   <= 1'b0;
            nak      <= 1'b0;
            tmo_err  <= 1'b0;
            batt_lvl <= 8'h00;
`ifdef CMD_ISSUE_RETRY_EN
            retry    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    snd_q <= 1'b0;
                    done  <= 1'b0;
                    if (go) begin
                        cmd_q   <= cmd_in;
                        data_q  <= data_in;
                        ack_ok  <= 1'b0;
                        tmo_err <= 1'b0;
                        busy    <= 1'b1;
`ifdef CMD_ISSUE_RETRY_EN
                        retry   <= '0;
`endif
                        if (code_valid) begin
                            nak   <= 1'b0;
                            snd_q <= 1'b1;
                            state <= SEND;
                        end else begin
                            // Unknown codes never reach the link.
                            nak   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                SEND: begin
                    snd_q <= 1'b0;
                    timer <= '0;
                    state <= WAIT_FRM;
                end
                WAIT_FRM, WAIT_RESP: begin
                    if (evt_ok) begin
                        if (cmd_q == REQ_BATT) begin
                            batt_lvl <= link.resp;
                        end
                        ack_ok <= 1'b1;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else if (evt_fail) begin
                        if (can_retry) begin
`ifdef CMD_ISSUE_RETRY_EN
                            retry <= retry + 1'b1;
`endif
                            snd_q <= 1'b1;
                            state <= SEND;
                        end else begin
                            nak     <= link.resp_rdy;
                            tmo_err <= !link.resp_rdy;
                            done    <= 1'b1;
                            state   <= FIN;
                        end
                    end else if (frm_now) begin
                        timer <= '0;
                        state <= WAIT_RESP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    snd_q <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - self-checking bench for cmd_issuer
module tb_cmd_issuer;

    localparam int TMO_W     = 4;
    localparam int MAX_RETRY = 2;
`ifdef CMD_ISSUE_RETRY_EN
    localparam int ATT = MAX_RETRY + 1;
`else
    localparam int ATT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [7:0]  cmd_in = 8'h00;
    logic [15:0] data_in = 16'h0000;
    logic        busy, done, ack_ok, nak, tmo_err;
    logic [7:0]  batt_lvl;

    cmd_issuer_if link();

    cmd_issuer #(.TMO_W(TMO_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .cmd_in   (cmd_in),
        .data_in  (data_in),
        .link     (link),
        .busy     (busy),
        .done     (done),
        .ack_ok   (ack_ok),
        .nak      (nak),
        .tmo_err  (tmo_err),
        .batt_lvl (batt_lvl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] m_batt = 8'h00;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  r;
        bit          stall;
        bit          use_frm;
        int          exp_snd;
        bit          ea;
        bit          en;
        bit          et;
        logic [7:0]  eb;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives one transaction while acting as a CommMaster responder.
    task automatic run_txn(input string tag, input logic [7:0] c, input logic [15:0] d,
                           input logic [7:0] r, input bit stall, input bit use_frm,
                           input int fdly, input int rdly, input int exp_snd,
                           input bit ea, input bit en, input bit et, input logic [7:0] eb);
        int pulses = 0;
        int first = 0;
        int dcyc = 0;
        int fcnt = -1;
        int rcnt = -1;
        bit seen = 0;
        bit busy_ok = 1;
        @(negedge clk);
        go = 1'b1; cmd_in = c; data_in = d;
        @(negedge clk);
        go = 1'b0; cmd_in = 8'($urandom); data_in = 16'($urandom);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            link.frm_snt = 1'b0;
            link.resp_rdy = 1'b0;
            if (done) begin
                seen = 1; dcyc = cyc;
                break;
            end
            if (!busy) busy_ok = 0;
            if (link.snd_cmd) begin
                pulses++;
                if (first == 0) first = cyc;
                if (!stall) begin
                    if (use_frm) fcnt = fdly;
                    else rcnt = fdly + rdly;
                end
            end else if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) begin
                    link.frm_snt = 1'b1; fcnt = -1; rcnt = rdly;
                end
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    link.resp_rdy = 1'b1; link.resp = r; rcnt = -1;
                end
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_snd_pulses"}, 32'(pulses), 32'(exp_snd));
        chk({tag, "_status"}, {29'd0, ack_ok, nak, tmo_err}, {29'd0, ea, en, et});
        chk({tag, "_batt"}, 32'(batt_lvl), 32'(eb));
        chk({tag, "_cmd_data"}, {8'd0, link.cmd, link.data}, {8'd0, c, d});
        chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        if (exp_snd > 0) chk({tag, "_first_snd_cycle"}, 32'(first), 32'd1);
        else chk({tag, "_invalid_done_latency"}, 32'(dcyc <= 2), 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    // Reference outcome from the behavioural rules, then run it.
    task automatic model_txn(input string tag, input logic [7:0] c, input logic [15:0] d,
                             input logic [7:0] r, input bit stall, input bit use_frm,
                             input int fdly, input int rdly);
        int esnd;
        bit ea = 0, en = 0, et = 0;
        if (c == 8'h00 || c > 8'h08) begin
            esnd = 0; en = 1;
        end else if (stall) begin
            esnd = ATT; et = 1;
        end else if (c == 8'h01) begin
            esnd = 1; ea = 1; m_batt = r;
        end else if (r == 8'hA5) begin
            esnd = 1; ea = 1;
        end else begin
            esnd = ATT; en = 1;
        end
        run_txn(tag, c, d, r, stall, use_frm, fdly, rdly, esnd, ea, en, et, m_batt);
    endtask

    initial begin
        int pulses;
        bit seen;
        bit quiet;
        link.frm_snt = 1'b0;
        link.resp_rdy = 1'b0;
        link.resp = 8'h00;

        tbl[0] = '{8'h01, 16'h0000, 8'h21, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 8'h21};
        tbl[1] = '{8'h02, 16'h0006, 8'hA5, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 8'h21};
        tbl[2] = '{8'h09, 16'h1111, 8'hA5, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 8'h21};
        tbl[3] = '{8'h00, 16'h2222, 8'hA5, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 8'h21};
        tbl[4] = '{8'h04, 16'h3333, 8'h00, 1'b1, 1'b1, ATT, 1'b0, 1'b0, 1'b1, 8'h21};
        tbl[5] = '{8'h08, 16'h4444, 8'h5A, 1'b0, 1'b1, ATT, 1'b0, 1'b1, 1'b0, 8'h21};
        tbl[6] = '{8'h06, 16'h5555, 8'hA5, 1'b0, 1'b0, 1,   1'b1, 1'b0, 1'b0, 8'h21};
        tbl[7] = '{8'h01, 16'h6666, 8'hA5, 1'b0, 1'b0, 1,   1'b1, 1'b0, 1'b0, 8'hA5};

        repeat (3) @(negedge clk);
        chk("rst_flags", {26'd0, busy, done, ack_ok, nak, tmo_err, link.snd_cmd}, 32'd0);
        chk("rst_cmd_data_batt", {link.cmd, link.data, batt_lvl}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].stall,
                    tbl[i].use_frm, 2, 3, tbl[i].exp_snd, tbl[i].ea, tbl[i].en, tbl[i].et, tbl[i].eb);
        end
        m_batt = 8'hA5;

        // go while busy must be ignored and the latched command stays put.
        @(negedge clk);
        go = 1'b1; cmd_in = 8'h02; data_in = 16'h1234;
        @(negedge clk);
        go = 1'b0;
        pulses = 0;
        if (link.snd_cmd) pulses++;
        @(negedge clk);
        if (link.snd_cmd) pulses++;
        go = 1'b1; cmd_in = 8'h03; data_in = 16'h5555;
        @(negedge clk);
        go = 1'b0;
        if (link.snd_cmd) pulses++;
        chk("busy_go_cmd_data", {8'd0, link.cmd, link.data}, {8'd0, 8'h02, 16'h1234});
        chk("busy_go_busy", 32'(busy), 32'd1);
        seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
            if (link.snd_cmd) pulses++;
        end
        chk("busy_go_done", 32'(seen), 32'd1);
        chk("busy_go_pulses", 32'(pulses), 32'(ATT));
        chk("busy_go_tmo", {29'd0, ack_ok, nak, tmo_err}, 32'd1);
        @(negedge clk);

        // Responses while idle are ignored.
        link.resp_rdy = 1'b1; link.frm_snt = 1'b1; link.resp = 8'h77;
        @(negedge clk);
        link.resp_rdy = 1'b0; link.frm_snt = 1'b0;
        @(negedge clk);
        chk("idle_noise", {15'd0, busy, done, link.snd_cmd, batt_lvl, 3'd0, tmo_err, 1'b0, 3'd0},
            {15'd0, 1'b0, 1'b0, 1'b0, m_batt, 3'd0, 1'b1, 1'b0, 3'd0});

        for (int n = 0; n < 30; n++) begin
            logic [7:0] c;
            logic [7:0] r;
            c = 8'($urandom_range(0, 10));
            if ($urandom_range(0, 3) != 0) c = 8'($urandom_range(1, 8));
            r = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
            model_txn($sformatf("rnd%0d", n), c, 16'($urandom), r,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(1, 4), $urandom_range(1, 4));
        end

        // Reset during WAIT_RESP, then a late response after release.
        @(negedge clk);
        go = 1'b1; cmd_in = 8'h03; data_in = 16'hBEEF;
        @(negedge clk);
        go = 1'b0;
        chk("rstmid_snd", 32'(link.snd_cmd), 32'd1);
        @(negedge clk);
        link.frm_snt = 1'b1;
        @(negedge clk);
        link.frm_snt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_flags", {26'd0, busy, done, ack_ok, nak, tmo_err, link.snd_cmd}, 32'd0);
        chk("rstmid_cmd_data_batt", {link.cmd, link.data, batt_lvl}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_batt = 8'h00;
        @(negedge clk);
        link.resp_rdy = 1'b1; link.resp = 8'hA5;
        @(negedge clk);
        link.resp_rdy = 1'b0;
        quiet = 1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (done || link.snd_cmd || busy) quiet = 0;
            @(negedge clk);
        end
        chk("late_resp_quiet", 32'(quiet), 32'd1);
        chk("late_resp_flags", {26'd0, busy, done, ack_ok, nak, tmo_err, link.snd_cmd}, 32'd0);
        chk("late_resp_cmd_data_batt", {link.cmd, link.data, batt_lvl}, 32'd0);

        model_txn("post_rst", 8'h01, 16'h0000, 8'h3C, 1'b0, 1'b1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
